// File: rtl/serial_frame_rx_if.sv
// Output word port of the serial frame receiver: a received word offered
// with a valid/ready handshake.
interface serial_frame_rx_if #(
    parameter int DATA_W = 4
) ();
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits MSB-first, optional even
// parity, stop bit; delivers words on a valid/ready port and flags errors.
module serial_frame_rx #(
    parameter int DATA_W    = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bit_en,
    input  logic                sin,
    serial_frame_rx_if.master   out,
    output logic                busy,
    output logic                frame_err,
    output logic                overrun
);
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic [DATA_W-1:0]   shreg_r, shreg_nxt_s;
    logic                par_r, par_nxt_s;
    logic                stop_s;
    logic                good_s;
    logic                free_s;
    logic [DATA_W-1:0]   dout_r;
    logic                dout_valid_r;
    logic                busy_r;
    logic                frame_err_r;
    logic                overrun_r;

    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Next-state, shift/count datapath and stop-bit evaluation; all gated by bit_en.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        shreg_nxt_s = shreg_r;
        par_nxt_s   = par_r;
        stop_s      = 1'b0;
        good_s      = 1'b0;
        if (bit_en) begin
            case (state_r)
                IDLE: begin
                    if (!sin) begin
                        state_nxt_s = DATA;
                        cnt_nxt_s   = '0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                DATA: begin
                    shreg_nxt_s = {shreg_r[DATA_W-2:0], sin};
                    if (cnt_r == CNT_LAST) begin
                        cnt_nxt_s   = '0;
                        state_nxt_s = PARITY_EN ? PARITY : STOP;
                    end else begin
                        cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                PARITY: begin
                    par_nxt_s   = sin;
                    state_nxt_s = STOP;
                end
                STOP: begin
                    stop_s      = 1'b1;
                    good_s      = sin && (!PARITY_EN || (par_r == even_par(shreg_r)));
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // A good frame may land only if the slot is empty or being drained this edge.
    assign free_s = !dout_valid_r || out.dout_ready;

    // FSM state and receive datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            shreg_r <= '0;
            par_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            shreg_r <= shreg_nxt_s;
            par_r   <= par_nxt_s;
        end
    end

    // Output word slot, handshake, status and error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            busy_r      <= (state_nxt_s != IDLE);
            frame_err_r <= stop_s && !good_s;
            overrun_r   <= stop_s && good_s && !free_s;
            if (stop_s && good_s && free_s) begin
                dout_r       <= shreg_r;
                dout_valid_r <= 1'b1;
            end else if (dout_valid_r && out.dout_ready) begin
                dout_valid_r <= 1'b0;
            end else begin
                dout_valid_r <= dout_valid_r;
            end
        end
    end

    assign out.dout       = dout_r;
    assign out.dout_valid = dout_valid_r;
    assign busy           = busy_r;
    assign frame_err      = frame_err_r;
    assign overrun        = overrun_r;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (DATA_W=4, even parity): a vector table
// of per-edge inputs and expected outputs, plus gated-sampling and async-reset sequences.
module tb_serial_frame_rx;
    logic clk;
    logic reset;
    logic bit_en;
    logic sin;
    logic busy;
    logic frame_err;
    logic overrun;

    serial_frame_rx_if #(.DATA_W(4)) rif ();

    serial_frame_rx #(.DATA_W(4), .PARITY_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_en    (bit_en),
        .sin       (sin),
        .out       (rif.master),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    typedef struct {
        logic       sin;
        logic       en;
        logic       rdy;
        logic [3:0] dout;
        logic       valid;
        logic       busy;
        logic       ferr;
        logic       ovr;
    } vec_t;

    vec_t vec_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic v(input logic s, input logic e, input logic r, input logic [3:0] d,
                     input logic vl, input logic b, input logic fe, input logic ov);
        vec_t t;
        t.sin = s; t.en = e; t.rdy = r; t.dout = d;
        t.valid = vl; t.busy = b; t.ferr = fe; t.ovr = ov;
        vec_q.push_back(t);
    endtask

    initial begin
        int busy_cnt;
        int err_cnt;
        logic [6:0] gbits;

        // Good frame 1001, parity 0, ready low; then consume.
        v(1'b0,1'b1,1'b0,4'h0,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h0,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h0,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h0,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h0,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h0,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b1,1'b0,1'b0,1'b0);
        v(1'b1,1'b1,1'b1,4'h9,1'b0,1'b0,1'b0,1'b0);
        // Parity error: data 1011, parity 0.
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b0,1'b0,1'b1,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b0,1'b0,1'b0,1'b0);
        // Stop-bit error.
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b0,1'b1,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b0,1'b0,1'b0,1'b0);
        // Overrun: 1001 held, 0110 dropped, then drain.
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b1,1'b0,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b1,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b1,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b1,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b1,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b1,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b1,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b1,1'b0,1'b0,1'b1);
        v(1'b1,1'b1,1'b1,4'h9,1'b0,1'b0,1'b0,1'b0);
        // Simultaneous consume and deliver: 1001 held, 0110 lands as ready rises.
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b1,1'b0,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b1,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b1,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b1,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h9,1'b1,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b1,1'b1,1'b0,1'b0);
        v(1'b0,1'b1,1'b0,4'h9,1'b1,1'b1,1'b0,1'b0);
        v(1'b1,1'b1,1'b1,4'h6,1'b1,1'b0,1'b0,1'b0);
        v(1'b1,1'b1,1'b0,4'h6,1'b1,1'b0,1'b0,1'b0);
        v(1'b1,1'b1,1'b1,4'h6,1'b0,1'b0,1'b0,1'b0);

        // Reset state.
        reset = 1'b0; bit_en = 1'b1; sin = 1'b1; rif.dout_ready = 1'b0;
        tick(); tick();
        reset = 1'b1;
        chk("rst_dout",  0, 16'(rif.dout), 16'h0);
        chk("rst_valid", 0, 16'(rif.dout_valid), 16'h0);
        chk("rst_busy",  0, 16'(busy), 16'h0);
        chk("rst_ferr",  0, 16'(frame_err), 16'h0);
        chk("rst_ovr",   0, 16'(overrun), 16'h0);
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        chk("idle_busy", 0, 16'(busy_cnt), 16'd0);

        // Table-driven vectors.
        for (int i = 0; i < vec_q.size(); i++) begin
            sin = vec_q[i].sin; bit_en = vec_q[i].en; rif.dout_ready = vec_q[i].rdy;
            tick();
            chk("dout",  i, 16'(rif.dout), 16'(vec_q[i].dout));
            chk("valid", i, 16'(rif.dout_valid), 16'(vec_q[i].valid));
            chk("busy",  i, 16'(busy), 16'(vec_q[i].busy));
            chk("ferr",  i, 16'(frame_err), 16'(vec_q[i].ferr));
            chk("ovr",   i, 16'(overrun), 16'(vec_q[i].ovr));
        end

        // Gated sampling: bit_en every 3rd cycle, sin inverted on unsampled cycles.
        gbits = 7'b0100101;
        busy_cnt = 0; err_cnt = 0; rif.dout_ready = 1'b0;
        for (int b = 6; b >= 0; b--) begin
            for (int k = 0; k < 3; k++) begin
                bit_en = (k == 2);
                sin    = (k == 2) ? gbits[b] : ~gbits[b];
                tick();
                if (busy) busy_cnt++;
                if (frame_err || overrun) err_cnt++;
            end
        end
        bit_en = 1'b1; sin = 1'b1;
        chk("gate_dout",  0, 16'(rif.dout), 16'h9);
        chk("gate_valid", 0, 16'(rif.dout_valid), 16'h1);
        chk("gate_busy",  0, 16'(busy_cnt), 16'd18);
        chk("gate_err",   0, 16'(err_cnt), 16'd0);

        // Async reset mid-DATA with a held word in the slot.
        sin = 1'b0; tick();
        sin = 1'b1; tick();
        sin = 1'b0; tick();
        chk("pre_busy", 0, 16'(busy), 16'h1);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy",  0, 16'(busy), 16'h0);
        chk("arst_valid", 0, 16'(rif.dout_valid), 16'h0);
        chk("arst_dout",  0, 16'(rif.dout), 16'h0);
        tick();
        reset = 1'b1; sin = 1'b1;
        tick();
        chk("post_busy", 0, 16'(busy), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the 4-bit shift register's serial output (its MSB shifted out, q[3]).
- Frames the serial bit stream: detects a start bit, shifts in DATA_W data bits MSB-first, checks an optional even-parity bit and the stop bit.
- Presents the assembled word on a valid/ready output port.
- Flags framing/parity errors and overruns.

Parameters:
- DATA_W, 4, number of data bits per frame (2..16).
- PARITY_EN, 1, 1 = frame carries an even-parity bit after the data; 0 = no parity bit.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- bit_en  input  1  sample strobe; sin is sampled only on clk edges where bit_en=1.
- sin  input  1  serial data in; line idles high.
- dout  output  DATA_W  received word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
- busy  output  1  high whenever the FSM is not in IDLE.
- frame_err  output  1  one-cycle pulse: bad stop bit or parity mismatch.
- overrun  output  1  one-cycle pulse: a good frame completed while the output was still full, and the frame was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; bit counter and shift register clear to 0.
  - dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0.
  - Reset asserted mid-frame discards the partial frame.
  - A valid but unconsumed word is also lost.
- All FSM transitions and samples below occur only on edges with bit_en=1. With bit_en=0 the FSM and the data registers hold, but the output handshake still operates.
- FSM states:
  - IDLE: sin=0 -> DATA, cnt=0; sin=1 -> stay.
  - DATA: shreg <= {shreg[DATA_W-2:0], sin}; cnt++. When cnt reaches DATA_W-1 on a sample, go to PARITY (if PARITY_EN) or STOP.
  - PARITY: latch the parity bit; -> STOP.
  - STOP: sample the stop bit and evaluate the frame; -> IDLE unconditionally.
- Frame evaluation (in STOP):
  - Good frame: sin=1 and, when PARITY_EN, the parity bit equals the XOR of the data bits.
  - Bad frame: frame_err pulses high for exactly the next cycle; dout and dout_valid are unchanged.
- Good frame delivery:
  - Output free (dout_valid=0, or dout_valid && dout_ready on the same edge): dout <= shreg, dout_valid <= 1 on that edge. Latency is 1 cycle from the stop-bit sample edge to dout_valid visible.
  - Output full (dout_valid=1 and dout_ready=0): the frame is dropped, overrun pulses for one cycle, and the held dout is preserved.
- Handshake:
  - dout_valid && dout_ready with no new word: dout_valid <= 0; dout keeps its last value.
  - dout must stay stable while dout_valid=1 and dout_ready=0.
- busy = (state != IDLE), registered. It goes high on the edge that accepts the start bit and low on the edge that samples the stop bit.
- Back-to-back frames: a start bit may be accepted on the first bit_en edge after STOP; no idle gap is required.
- A sin glitch to 0 in IDLE is treated as a start bit; there is no false-start filtering.

Test Plan:
- Reset state: hold reset=0 for 2 cycles, then release -> dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0; sin=1 idle for 10 cycles keeps busy=0.
- Good frame (DATA_W=4, PARITY_EN=1, bit_en=1 constant): sin sequence 0,1,0,0,1,0,1 -> one cycle after the stop sample, dout=4'b1001 and dout_valid=1; busy was high for exactly 6 cycles; no error pulses.
- Parity and stop errors:
  - Parity: frame 0,1,0,1,1,0,1 (data 1011, parity 0 wrong) -> frame_err pulses once; dout_valid stays 0.
  - Stop: frame 0,1,0,0,1,0,0 (stop bit 0) -> frame_err pulses once; dout_valid stays 0.
- Overrun: dout_ready=0; receive 1001 then a good frame with data 0110 (parity 0) -> overrun pulses once and dout stays 4'b1001. Then raise dout_ready -> dout_valid drops the next cycle.
- Simultaneous consume and deliver: dout_valid=1 with dout=1001; dout_ready=1 on the same edge the 0110 stop bit is sampled -> dout=0110, dout_valid stays 1, no overrun.
- Gated sampling and async reset:
  - bit_en pulsed every 3rd cycle with frame 1001 -> the same result as the good-frame case.
  - reset driven low mid-DATA, between clock edges -> busy=0 and dout_valid=0 immediately, before the next edge.
